rtc_cr_read_ctrl: RTL and testbench

- Upstream read sequencer for the chronometer holding registers (seconds, minutes, hours) fed from the external RTC over its multiplexed address/data bus.
- On each start request it sweeps the three chronometer addresses and generates the RTC bus strobes for each one.
- It captures each returned byte onto a shared data output and pulses a one-hot enable so exactly one downstream holding register latches it.

---
 rtl/rtc_cr_pkg.sv | 37 +++
 rtl/rtc_cr_read_ctrl_timer.sv | 34 +++
 rtl/rtc_cr_read_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rtc_cr_read_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_cr_pkg.sv
// Shared types and constants for the RTC chronometer read sequencer.
package rtc_cr_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned EN_W   = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR_WR   = 3'd1,
    ADDR_HOLD = 3'd2,
    GAP       = 3'd3,
    DATA_RD   = 3'd4,
    DATA_REC  = 3'd5,
    DONE      = 3'd6
  } state_e;

  localparam logic [DATA_W-1:0] DEF_ADDR_SEG  = 8'h41;
  localparam logic [DATA_W-1:0] DEF_ADDR_MIN  = 8'h42;
  localparam logic [DATA_W-1:0] DEF_ADDR_HORA = 8'h43;

  localparam logic [IDX_W-1:0] IDX_SEG  = 2'd0;
  localparam logic [IDX_W-1:0] IDX_MIN  = 2'd1;
  localparam logic [IDX_W-1:0] IDX_HORA = 2'd2;

  // RTC bus control bundle; strobes are active-low.
  typedef struct packed {
    logic cs_n;
    logic rd_n;
    logic wr_n;
    logic a_d;
    logic ad_oe;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_IDLE = '{cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, a_d: 1'b0, ad_oe: 1'b0};

endpackage

// File: rtl/rtc_cr_read_ctrl_timer.sv
// Phase down-counter: loads at each phase entry, flags the last cycle of the phase.
module rtc_phase_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_c = (cnt_q == '0);

endmodule

// File: rtl/rtc_cr_read_ctrl.sv
// Sweeps the seconds/minutes/hours RTC registers over the multiplexed AD bus
// and pulses a one-hot latch enable as each byte lands on dato.
module rtc_cr_read_ctrl
  import rtc_cr_pkg::*;
#(
  parameter int unsigned       T_PHASE   = 8,
  parameter logic [DATA_W-1:0] ADDR_SEG  = DEF_ADDR_SEG,
  parameter logic [DATA_W-1:0] ADDR_MIN  = DEF_ADDR_MIN,
  parameter logic [DATA_W-1:0] ADDR_HORA = DEF_ADDR_HORA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic [DATA_W-1:0] dato,
  output logic              en_seg,
  output logic              en_min,
  output logic              en_hora,
  output logic              busy,
  output logic              done
);

  localparam int unsigned      CNT_W   = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(T_PHASE - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              load_c;
  logic [CNT_W-1:0]  load_val_c;
  logic              last_c;

  bus_ctl_t          ctl_q, ctl_d;
  logic [DATA_W-1:0] ad_out_q, ad_out_d;
  logic [DATA_W-1:0] dato_q, dato_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [DATA_W-1:0] addr_of(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_MIN:  addr_of = ADDR_MIN;
      IDX_HORA: addr_of = ADDR_HORA;
      default:  addr_of = ADDR_SEG;
    endcase
  endfunction

  rtc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (load_c),
    .load_val(load_val_c),
    .last_c  (last_c)
  );

  // Next state, register index, phase reload and data capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load_c     = 1'b0;
    load_val_c = PH_LAST;
    dato_d     = dato_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ADDR_WR;
          idx_d   = IDX_SEG;
          load_c  = 1'b1;
        end
      end
      ADDR_WR: begin
        if (last_c) begin
          state_d    = ADDR_HOLD;
          load_c     = 1'b1;
          load_val_c = '0;
        end
      end
      ADDR_HOLD: begin
        state_d = GAP;
        load_c  = 1'b1;
      end
      GAP: begin
        if (last_c) begin
          state_d = DATA_RD;
          load_c  = 1'b1;
        end
      end
      DATA_RD: begin
        if (last_c) begin
          state_d = DATA_REC;
          load_c  = 1'b1;
          dato_d  = ad_in;
        end
      end
      DATA_REC: begin
        if (last_c) begin
          if (idx_q == IDX_HORA) begin
            state_d = DONE;
          end else begin
            state_d = ADDR_WR;
            idx_d   = idx_q + IDX_W'(1);
            load_c  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    ctl_d    = BUS_IDLE;
    ad_out_d = ad_out_q;
    en_d     = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_d)
      ADDR_WR: begin
        ctl_d.cs_n  = 1'b0;
        ctl_d.wr_n  = 1'b0;
        ctl_d.ad_oe = 1'b1;
        ad_out_d    = addr_of(idx_d);
        busy_d      = 1'b1;
      end
      ADDR_HOLD: begin
        ctl_d.ad_oe = 1'b1;
        busy_d      = 1'b1;
      end
      GAP: begin
        busy_d = 1'b1;
      end
      DATA_RD: begin
        ctl_d.cs_n = 1'b0;
        ctl_d.rd_n = 1'b0;
        ctl_d.a_d  = 1'b1;
        busy_d     = 1'b1;
      end
      DATA_REC: begin
        ctl_d.a_d = 1'b1;
        busy_d    = 1'b1;
        if (state_q == DATA_RD) begin
          en_d = EN_W'(1) << idx_d;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= IDX_SEG;
      ctl_q    <= BUS_IDLE;
      ad_out_q <= '0;
      dato_q   <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ctl_q    <= ctl_d;
      ad_out_q <= ad_out_d;
      dato_q   <= dato_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ctl_q.ad_oe;
  assign cs_n    = ctl_q.cs_n;
  assign rd_n    = ctl_q.rd_n;
  assign wr_n    = ctl_q.wr_n;
  assign a_d     = ctl_q.a_d;
  assign dato    = dato_q;
  assign en_seg  = en_q[IDX_SEG];
  assign en_min  = en_q[IDX_MIN];
  assign en_hora = en_q[IDX_HORA];
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rtc_cr_read_ctrl.sv
// Bench for rtc_cr_read_ctrl: T_PHASE=8 instance with an RTC bus model and
// scoreboard, plus a T_PHASE=2 instance for back-to-back sweeps.
module tb_rtc_cr_read_ctrl;

  typedef struct packed {
    logic [2:0] en;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       start8, ad_oe8, cs8_n, rd8_n, wr8_n, a_d8;
  logic       en_seg8, en_min8, en_hora8, busy8, done8;
  logic [7:0] ad_in8, ad_out8, dato8;

  logic       start2, ad_oe2, cs2_n, rd2_n, wr2_n, a_d2;
  logic       en_seg2, en_min2, en_hora2, busy2, done2;
  logic [7:0] ad_in2, ad_out2, dato2;

  rtc_cr_read_ctrl #(.T_PHASE(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .ad_in(ad_in8), .ad_out(ad_out8),
    .ad_oe(ad_oe8), .cs_n(cs8_n), .rd_n(rd8_n), .wr_n(wr8_n), .a_d(a_d8),
    .dato(dato8), .en_seg(en_seg8), .en_min(en_min8), .en_hora(en_hora8),
    .busy(busy8), .done(done8)
  );

  rtc_cr_read_ctrl #(.T_PHASE(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .ad_in(ad_in2), .ad_out(ad_out2),
    .ad_oe(ad_oe2), .cs_n(cs2_n), .rd_n(rd2_n), .wr_n(wr2_n), .a_d(a_d2),
    .dato(dato2), .en_seg(en_seg2), .en_min(en_min2), .en_hora(en_hora2),
    .busy(busy2), .done(done2)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  // RTC model: latches the address phase, drives data only while rd_n is low.
  logic [7:0] rtc_addr;
  always @(posedge clk) begin
    if (!cs8_n && !wr8_n && ad_oe8) rtc_addr <= ad_out8;
  end
  always_comb begin
    ad_in8 = 8'hEE;
    if (!rd8_n) begin
      case (rtc_addr)
        8'h41:   ad_in8 = 8'h37;
        8'h42:   ad_in8 = 8'h12;
        8'h43:   ad_in8 = 8'h09;
        default: ad_in8 = 8'hFF;
      endcase
    end
  end
  assign ad_in2 = (!rd2_n) ? 8'h5A : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and bus-protocol monitor for the T_PHASE=8 instance.
  int         en_cnt8 = 0, done_cnt8 = 0, cs_hi_run = 0, rel_run = 0;
  logic       rd8_prev = 1'b1, hold_chk = 1'b0;
  logic [7:0] hold_val;
  logic [2:0] en_v8;
  exp_t       e8;
  always @(negedge clk) begin
    en_v8 = {en_hora8, en_min8, en_seg8};
    if (!reset) begin
      rd8_prev = 1'b1;
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) check("dato8_hold", dato8, hold_val);
      hold_chk = 1'b0;
      if (en_v8 != 3'b000) begin
        en_cnt8++;
        check("en8_onehot", $onehot(en_v8), 1);
        if (sb.size() == 0) begin
          check("en8_unexpected", sb.size(), 1);
        end else begin
          e8 = sb.pop_front();
          check("en8_sel", en_v8, e8.en);
          check("dato8_at_en", dato8, e8.data);
          hold_chk = 1'b1;
          hold_val = e8.data;
        end
      end
      if (done8) begin
        done_cnt8++;
        check("busy8_at_done", busy8, 0);
      end
      if (!wr8_n) begin
        check("oe8_during_wr", ad_oe8, 1);
        if (sb.size() == 0) check("addr8_unexpected", sb.size(), 1);
        else check("addr8", ad_out8, sb[0].addr);
      end
      if (!rd8_n) begin
        check("oe8_during_rd", ad_oe8, 0);
        check("a_d8_during_rd", a_d8, 1);
        if (rd8_prev) begin
          check("turnaround8", rel_run, 8);
          check("cs8_high_min", cs_hi_run >= 8, 1);
        end
      end
      if (cs8_n) begin
        cs_hi_run++;
        if (!ad_oe8) rel_run++;
      end else begin
        cs_hi_run = 0;
        rel_run   = 0;
      end
      rd8_prev = rd8_n;
    end
  end

  // Monitor for the T_PHASE=2 instance: ordering, one-hot, data, bus sanity.
  int         en_cnt2 = 0, done_cnt2 = 0, idx2 = 0;
  logic [2:0] en_v2;
  always @(negedge clk) begin
    en_v2 = {en_hora2, en_min2, en_seg2};
    if (reset) begin
      if (en_v2 != 3'b000) begin
        en_cnt2++;
        check("en2_onehot", $onehot(en_v2), 1);
        check("en2_order", en_v2, 3'b001 << idx2);
        check("dato2_at_en", dato2, 8'h5A);
        idx2 = (idx2 + 1) % 3;
      end
      if (done2) done_cnt2++;
      if (!wr2_n) check("addr2", ad_out2, 8'h41 + idx2);
      if (!rd2_n) begin
        check("oe2_during_rd", ad_oe2, 0);
        check("a_d2_during_rd", a_d2, 1);
      end
    end
  end

  task automatic push_sweep();
    sb.push_back('{en: 3'b001, addr: 8'h41, data: 8'h37});
    sb.push_back('{en: 3'b010, addr: 8'h42, data: 8'h12});
    sb.push_back('{en: 3'b100, addr: 8'h43, data: 8'h09});
  endtask

  int n, e0, d0;
  logic prev_busy;

  initial begin
    reset  = 1'b0;
    start8 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n",   cs8_n, 1);
    check("rst_rd_n",   rd8_n, 1);
    check("rst_wr_n",   wr8_n, 1);
    check("rst_a_d",    a_d8, 0);
    check("rst_ad_oe",  ad_oe8, 0);
    check("rst_ad_out", ad_out8, 0);
    check("rst_dato",   dato8, 0);
    check("rst_en",     {en_hora8, en_min8, en_seg8}, 0);
    check("rst_busy",   busy8, 0);
    check("rst_done",   done8, 0);
    check("rst2_busy",  busy2, 0);
    reset = 1'b1;
    @(negedge clk);

    // Basic sweep: length, busy/done alignment.
    push_sweep();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("first_addr_wr", wr8_n, 0);
    check("busy8_after_start", busy8, 1);
    n = 1;
    prev_busy = busy8;
    while (!done8 && n < 300) begin
      prev_busy = busy8;
      @(negedge clk);
      n++;
    end
    check("sweep8_done_seen", done8, 1);
    check("sweep8_len", n, 100);
    check("busy8_before_done", prev_busy, 1);
    check("sb_empty_basic", sb.size(), 0);
    check("dato8_final", dato8, 8'h09);
    @(negedge clk);

    // Start pulses while busy must be ignored.
    e0 = en_cnt8;
    d0 = done_cnt8;
    push_sweep();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (19) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (39) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (150) @(negedge clk);
    check("busy_start_en_cnt", en_cnt8 - e0, 3);
    check("busy_start_done_cnt", done_cnt8 - d0, 1);
    check("sb_empty_busy", sb.size(), 0);

    // Reset in the minutes data read.
    e0 = en_cnt8;
    push_sweep();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (en_cnt8 == e0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("seg_en_seen", en_cnt8 - e0, 1);
    n = 0;
    while (rd8_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("min_rd_seen", rd8_n, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_cs_n", cs8_n, 1);
    check("midrst_rd_n", rd8_n, 1);
    check("midrst_dato", dato8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_ad_oe", ad_oe8, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    e0 = en_cnt8;
    repeat (60) @(negedge clk);
    check("no_en_after_rst", en_cnt8 - e0, 0);
    check("idle_after_rst", busy8, 0);
    d0 = done_cnt8;
    push_sweep();
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("resweep_addr", ad_out8, 8'h41);
    repeat (110) @(negedge clk);
    check("resweep_en_cnt", en_cnt8 - e0, 3);
    check("resweep_done_cnt", done_cnt8 - d0, 1);
    check("sb_empty_resweep", sb.size(), 0);

    // Back-to-back sweeps with T_PHASE=2 and start held high.
    start2 = 1'b1;
    for (int s = 0; s < 2; s++) begin
      n = 0;
      while (wr2_n && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t2_addr_wr_seen", wr2_n, 0);
      n = 1;
      while (!done2 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("t2_done_seen", done2, 1);
      check("t2_sweep_len", n, 28);
      @(negedge clk);
      check("t2_idle_busy", busy2, 0);
      check("t2_idle_wr_n", wr2_n, 1);
      check("t2_idle_done", done2, 0);
      if (s == 0) begin
        @(negedge clk);
        check("t2_next_addr_wr", wr2_n, 0);
      end else begin
        start2 = 1'b0;
      end
    end
    repeat (10) @(negedge clk);
    check("t2_en_cnt", en_cnt2, 6);
    check("t2_done_cnt", done_cnt2, 2);
    check("t2_stopped", busy2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
